device_bus_arbiter: RTL and testbench

//  Shares the 16-bit device bus (write_en/address/data) between two masters:

---
 rtl/device_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_device_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/device_bus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit device bus, with optional burst lock.
// Each access runs IDLE -> ISSUE -> COMPLETE to match the devices' one-cycle read latency.
module device_bus_arbiter #(
  parameter int LOCK_TIMEOUT = 16,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  cpu_clock,
  input  logic                  reset,
  input  logic [1:0]            m_req,
  input  logic [1:0]            m_we,
  input  logic [1:0]            m_lock,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [15:0]           m0_data_out,
  input  logic [15:0]           m1_data_out,
  output logic [1:0]            m_ack,
  output logic [15:0]           m_data_in,
  output logic                  owner,
  output logic                  device_write_en,
  output logic [ADDR_WIDTH-1:0] device_address,
  output logic [15:0]           device_data_out,
  input  logic [15:0]           device_data_in
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  lock_q, lock_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_lat_q, we_lat_d;
  logic                  dev_we_q, dev_we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            ack_q, ack_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  grant_s;
  logic                  gnt_m_s;

  // Next-state, arbitration and bus-register update logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lock_d   = lock_q;
    tmo_d    = tmo_q;
    we_lat_d = we_lat_q;
    dev_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = 2'b00;
    rdata_d  = rdata_q;
    grant_s  = 1'b0;
    gnt_m_s  = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (lock_q) begin
          // A locked owner keeps the bus; the other master waits out the timeout.
          if (m_req[owner_q]) begin
            grant_s = 1'b1;
            gnt_m_s = owner_q;
          end else if (tmo_q >= TMO_LAST) begin
            lock_d = 1'b0;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else if (m_req == 2'b11) begin
          grant_s = 1'b1;
          gnt_m_s = ~owner_q;
        end else if (m_req[0]) begin
          grant_s = 1'b1;
          gnt_m_s = 1'b0;
        end else if (m_req[1]) begin
          grant_s = 1'b1;
          gnt_m_s = 1'b1;
        end else begin
          grant_s = 1'b0;
        end

        if (grant_s) begin
          state_d  = ST_ISSUE;
          owner_d  = gnt_m_s;
          we_lat_d = m_we[gnt_m_s];
          dev_we_d = m_we[gnt_m_s];
          addr_d   = gnt_m_s ? m1_address  : m0_address;
          wdata_d  = gnt_m_s ? m1_data_out : m0_data_out;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // Device read data is valid at the end of the address cycle.
        state_d = ST_COMPLETE;
        ack_d   = owner_q ? 2'b10 : 2'b01;
        if (!we_lat_q) begin
          rdata_d = device_data_in;
        end else begin
          rdata_d = rdata_q;
        end
      end

      ST_COMPLETE: begin
        state_d = ST_IDLE;
        lock_d  = m_lock[owner_q];
        tmo_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b1;
      lock_q   <= 1'b0;
      tmo_q    <= '0;
      we_lat_q <= 1'b0;
      dev_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      ack_q    <= 2'b00;
      rdata_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      tmo_q    <= tmo_d;
      we_lat_q <= we_lat_d;
      dev_we_q <= dev_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign m_ack           = ack_q;
  assign m_data_in       = rdata_q;
  assign owner           = owner_q;
  assign device_write_en = dev_we_q;
  assign device_address  = addr_q;
  assign device_data_out = wdata_q;

endmodule

// File: tb/tb_device_bus_arbiter.sv
// Directed bench for device_bus_arbiter: table of single accesses plus
// hand-written round-robin, lock, lock-timeout and reset-mid-access sequences.
module tb_device_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_req, m_we, m_lock, m_ack;
  logic [15:0] m0_addr, m1_addr, m0_dout, m1_dout;
  logic [15:0] m_data_in, dev_addr, dev_dout, dev_din;
  logic        owner, dev_we;

  int nvec = 0;
  int misc = 0;

  typedef struct {
    logic        m;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] exp_din;
  } vec_t;

  vec_t tbl[6];

  device_bus_arbiter #(.LOCK_TIMEOUT(16), .ADDR_WIDTH(16)) dut (
    .cpu_clock       (clk),
    .reset           (rst_n),
    .m_req           (m_req),
    .m_we            (m_we),
    .m_lock          (m_lock),
    .m0_address      (m0_addr),
    .m1_address      (m1_addr),
    .m0_data_out     (m0_dout),
    .m1_data_out     (m1_dout),
    .m_ack           (m_ack),
    .m_data_in       (m_data_in),
    .owner           (owner),
    .device_write_en (dev_we),
    .device_address  (dev_addr),
    .device_data_out (dev_dout),
    .device_data_in  (dev_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One isolated access from IDLE; the idle master carries junk that must be ignored.
  task automatic do_access(input vec_t v);
    m_req  = v.m ? 2'b10 : 2'b01;
    m_we   = v.m ? {v.we, 1'b1} : {1'b1, v.we};
    if (v.m) begin
      m1_addr = v.addr;  m1_dout = v.wdata;
      m0_addr = 16'hDEAD; m0_dout = 16'hBAD0;
    end else begin
      m0_addr = v.addr;  m0_dout = v.wdata;
      m1_addr = 16'hDEAD; m1_dout = 16'hBAD1;
    end
    tick();
    chk("issue_we", 32'(dev_we), 32'(v.we));
    chk("issue_addr", 32'(dev_addr), 32'(v.addr));
    chk("issue_owner", 32'(owner), 32'(v.m));
    if (v.we) chk("issue_data", 32'(dev_dout), 32'(v.wdata));
    chk("issue_noack", 32'(m_ack), 32'd0);
    dev_din = v.rdata;
    tick();
    chk("cmpl_ack", 32'(m_ack), v.m ? 32'd2 : 32'd1);
    chk("cmpl_din", 32'(m_data_in), 32'(v.exp_din));
    chk("cmpl_we", 32'(dev_we), 32'd0);
    m_req = 2'b00;
    tick();
    chk("idle_noack", 32'(m_ack), 32'd0);
  endtask

  initial begin
    int n;
    logic exp_m;

    tbl[0] = '{1'b0, 1'b1, 16'h0040, 16'h00A5, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 16'h4000, 16'h0000, 16'h1234, 16'h1234};
    tbl[2] = '{1'b0, 1'b0, 16'h0123, 16'h0000, 16'hBEEF, 16'hBEEF};
    tbl[3] = '{1'b1, 1'b1, 16'hFFFF, 16'h5A5A, 16'hDEAD, 16'hBEEF};
    tbl[4] = '{1'b0, 1'b1, 16'h8001, 16'h0001, 16'h7777, 16'hBEEF};
    tbl[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};

    rst_n = 1'b0; m_req = 2'b00; m_we = 2'b00; m_lock = 2'b00;
    m0_addr = 16'h0000; m1_addr = 16'h0000; m0_dout = 16'h0000; m1_dout = 16'h0000;
    dev_din = 16'h0000;

    // Reset values
    #12;
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_din", 32'(m_data_in), 32'd0);
    chk("rst_owner", 32'(owner), 32'd1);
    chk("rst_we", 32'(dev_we), 32'd0);
    chk("rst_addr", 32'(dev_addr), 32'd0);
    chk("rst_dout", 32'(dev_dout), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_we", 32'(dev_we), 32'd0);
    end

    for (int i = 0; i < 6; i++) do_access(tbl[i]);

    // Both masters requesting continuously: strict alternation, one access per 3 cycles
    m_req = 2'b11; m_we = 2'b11;
    m0_addr = 16'hA000; m0_dout = 16'h000A;
    m1_addr = 16'hB000; m1_dout = 16'h000B;
    exp_m = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_we", 32'(dev_we), 32'd1);
      chk("rr_owner", 32'(owner), 32'(exp_m));
      chk("rr_addr", 32'(dev_addr), exp_m ? 32'hB000 : 32'hA000);
      tick();
      chk("rr_ack", 32'(m_ack), exp_m ? 32'd2 : 32'd1);
      if (i == 5) m_req = 2'b00;
      tick();
      chk("rr_gap", 32'(m_ack), 32'd0);
      exp_m = ~exp_m;
    end

    // Master 1 locked burst of 3 reads while master 0 waits
    m_we = 2'b01; m_lock = 2'b10;
    m0_addr = 16'h3000; m0_dout = 16'h3333; m1_addr = 16'h2000;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) m_req = 2'b10;
      tick();
      chk("lk_owner", 32'(owner), 32'd1);
      chk("lk_we", 32'(dev_we), 32'd0);
      chk("lk_addr", 32'(dev_addr), 32'h2000);
      m_req = 2'b11;
      dev_din = 16'h0100 + 16'(i);
      if (i == 2) m_lock = 2'b00;
      tick();
      chk("lk_ack", 32'(m_ack), 32'd2);
      chk("lk_din", 32'(m_data_in), 32'h0100 + 32'(i));
      if (i == 2) m_req = 2'b01;
      tick();
    end
    tick();
    chk("unlk_owner", 32'(owner), 32'd0);
    chk("unlk_we", 32'(dev_we), 32'd1);
    chk("unlk_addr", 32'(dev_addr), 32'h3000);
    chk("unlk_dout", 32'(dev_dout), 32'h3333);
    tick();
    chk("unlk_ack", 32'(m_ack), 32'd1);
    m_req = 2'b00;
    tick();

    // Master 1 locks then walks away: master 0 waits out the 16-cycle timeout
    m_req = 2'b10; m_lock = 2'b10; m_we = 2'b01; m1_addr = 16'h5000;
    m0_addr = 16'h6000; m0_dout = 16'h6666;
    tick();
    chk("to_owner1", 32'(owner), 32'd1);
    dev_din = 16'h5555;
    tick();
    chk("to_ack1", 32'(m_ack), 32'd2);
    m_req = 2'b01;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (i == 0) m_lock = 2'b00;
      if (dev_we) break;
    end
    chk("to_wait", 32'(n), 32'd18);
    chk("to_owner0", 32'(owner), 32'd0);
    chk("to_addr", 32'(dev_addr), 32'h6000);
    tick();
    chk("to_ack0", 32'(m_ack), 32'd1);
    m_req = 2'b00;
    tick();

    // Reset pulsed during ISSUE: access abandoned, no ack afterwards
    m_req = 2'b01; m_we = 2'b01; m0_addr = 16'h0777; m0_dout = 16'h0707;
    tick();
    chk("ri_we", 32'(dev_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ri_we0", 32'(dev_we), 32'd0);
    chk("ri_owner", 32'(owner), 32'd1);
    chk("ri_addr", 32'(dev_addr), 32'd0);
    m_req = 2'b00;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ri_noack", 32'(m_ack), 32'd0);
    end
    do_access('{1'b1, 1'b0, 16'h7000, 16'h0000, 16'h7777, 16'h7777});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, misc);
    $finish;
  end

endmodule
